// File: rtl/mem_access_if.sv
// Data-memory port of the memory stage.
//   mem_req    request valid; address, write flag, byte enables and write data
//              are held stable while mem_req=1 and mem_ready=0.
//   mem_we     1 = write, 0 = read.
//   mem_addr   word-aligned address.
//   mem_be     byte enables (all ones for reads).
//   mem_wdata  lane-replicated write data.
//   mem_ready  memory accepts the request in this cycle.
//   mem_rvalid read data valid (one pulse per accepted read).
//   mem_rdata  read word.
// Handshake: a request transfers on a cycle where mem_req && mem_ready. A read
// then completes on a later cycle with mem_rvalid=1; there is no backpressure
// on the read response.
interface mem_access_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_access.sv
// Memory stage. Takes one executed instruction at a time from execute, performs
// byte/halfword/word loads and stores over the data-memory port and presents a
// single registered result pulse to writeback.
// Ports:
//   sys_clk, rst        clock (rising edge), asynchronous active-high reset
//   ex_*                executed instruction (valid, opcode, load/store flag,
//                       ALU result / effective address, store data, rd, reg write)
//   stall               execute must hold its outputs (ex_valid && state != IDLE)
//   mem                 data-memory port (mem_access_if.master)
//   wb_*                one-cycle result pulse to writeback
//   addr_err            misaligned access, qualified by wb_valid
//   state_dbg           FSM state: 0 = IDLE, 1 = REQ, 2 = WAIT
// An instruction is accepted in any cycle where the FSM is IDLE and ex_valid=1.
module mem_access #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [5:0]  ex_opcode,
  input  logic        ex_is_load_store,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  output logic        stall,
  mem_access_if.master mem,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        addr_err,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t state, state_nxt;

  // Decode of the incoming instruction
  logic        dec_mem, dec_load, dec_unsigned, misaligned;
  logic [1:0]  dec_size, st_lane;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  // Access latched at accept
  logic        load_q, unsigned_q, reg_write_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [4:0]  rd_q;

  // Load extraction
  logic [1:0]  ld_lane;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;

  // Opcodes outside the eight memory ops are passed through like ALU ops,
  // even if ex_is_load_store is set.
  always_comb begin
    dec_mem      = 1'b1;
    dec_load     = 1'b0;
    dec_unsigned = 1'b0;
    dec_size     = SZ_WORD;
    case (ex_opcode)
      6'b100000: begin dec_load = 1'b1; dec_size = SZ_BYTE; end
      6'b100001: begin dec_load = 1'b1; dec_size = SZ_HALF; end
      6'b100011: begin dec_load = 1'b1; dec_size = SZ_WORD; end
      6'b100100: begin dec_load = 1'b1; dec_size = SZ_BYTE; dec_unsigned = 1'b1; end
      6'b100101: begin dec_load = 1'b1; dec_size = SZ_HALF; dec_unsigned = 1'b1; end
      6'b101000: dec_size = SZ_BYTE;
      6'b101001: dec_size = SZ_HALF;
      6'b101011: dec_size = SZ_WORD;
      default:   dec_mem = 1'b0;
    endcase
    dec_mem = dec_mem & ex_is_load_store;
  end

  assign misaligned = ((dec_size == SZ_HALF) && ex_result[0]) ||
                      ((dec_size == SZ_WORD) && (ex_result[1:0] != 2'b00));

  // Big-endian reverses the byte order inside the word: lane = 3 - addr[1:0].
  assign st_lane = BIG_ENDIAN ? ~ex_result[1:0] : ex_result[1:0];

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = ex_store_data;
    if (!dec_load) begin
      case (dec_size)
        SZ_BYTE: begin
          st_be    = 4'b0001 << st_lane;
          st_wdata = {4{ex_store_data[7:0]}};
        end
        SZ_HALF: begin
          st_be    = (ex_result[1] ^ BIG_ENDIAN) ? 4'b1100 : 4'b0011;
          st_wdata = {2{ex_store_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign ld_lane = BIG_ENDIAN ? ~addr_q[1:0] : addr_q[1:0];

  always_comb begin
    ld_byte = mem.mem_rdata[7:0];
    case (ld_lane)
      2'd1:    ld_byte = mem.mem_rdata[15:8];
      2'd2:    ld_byte = mem.mem_rdata[23:16];
      2'd3:    ld_byte = mem.mem_rdata[31:24];
      default: ;
    endcase
    ld_half = (addr_q[1] ^ BIG_ENDIAN) ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (size_q)
      SZ_BYTE: ld_value = unsigned_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_value = unsigned_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_value = mem.mem_rdata;
    endcase
  end

  // FSM: state register
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (ex_valid && dec_mem && !misaligned) state_nxt = REQ;
      REQ:  if (mem.mem_ready) state_nxt = load_q ? WAIT : IDLE;
      WAIT: if (mem.mem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs. mem_req is decoded from state so it drops as soon as rst rises.
  always_comb begin
    mem.mem_req = (state == REQ);
    stall       = ex_valid && (state != IDLE);
    state_dbg   = state;
  end

  assign mem.mem_we    = ~load_q;
  assign mem.mem_addr  = {addr_q[31:2], 2'b00};
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;

  // Latched access and writeback result
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      load_q       <= 1'b1;
      unsigned_q   <= 1'b0;
      reg_write_q  <= 1'b0;
      size_q       <= SZ_BYTE;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      rd_q         <= '0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      addr_err     <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      addr_err <= 1'b0;
      case (state)
        IDLE: if (ex_valid) begin
          if (dec_mem) begin
            load_q      <= dec_load;
            unsigned_q  <= dec_unsigned;
            size_q      <= dec_size;
            addr_q      <= ex_result;
            wdata_q     <= st_wdata;
            be_q        <= st_be;
            rd_q        <= ex_rd;
            reg_write_q <= ex_reg_write;
            if (misaligned) begin
              wb_valid     <= 1'b1;
              addr_err     <= 1'b1;
              wb_data      <= ex_result;
              wb_rd        <= ex_rd;
              wb_reg_write <= 1'b0;
            end
          end else begin
            wb_valid     <= 1'b1;
            wb_data      <= ex_result;
            wb_rd        <= ex_rd;
            wb_reg_write <= ex_reg_write;
          end
        end
        REQ: if (mem.mem_ready && !load_q) begin
          wb_valid     <= 1'b1;
          wb_data      <= addr_q;
          wb_rd        <= rd_q;
          wb_reg_write <= 1'b0;
        end
        WAIT: if (mem.mem_rvalid) begin
          wb_valid     <= 1'b1;
          wb_data      <= ld_value;
          wb_rd        <= rd_q;
          wb_reg_write <= reg_write_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage directly downstream of the execute stage.
- Accepts each executed instruction: ALU result or effective address, plus store data.
- Performs byte/halfword/word loads and stores over a ready/valid data-memory port, extracting and extending load data.
- Presents one registered result per instruction to writeback, stalling execute while a memory access is outstanding.

Parameters:
- BIG_ENDIAN, 0, lane mapping: 0 = byte at addr[1:0]=0 is bits [7:0]; 1 = byte at addr[1:0]=0 is bits [31:24].

Ports:
- sys_clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  execute output holds a valid instruction.
- ex_opcode  in  6  instruction opcode; memory ops: lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101, sb 101000, sh 101001, sw 101011.
- ex_is_load_store  in  1  instruction is a load or store.
- ex_result  in  32  ALU result; effective address for memory ops.
- ex_store_data  in  32  rt value for stores.
- ex_rd  in  5  destination register.
- ex_reg_write  in  1  instruction writes a register.
- stall  out  1  execute must hold its outputs.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ready  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word.
- wb_valid  out  1  one-cycle pulse; result available.
- wb_data  out  32  result, or faulting address when addr_err=1.
- wb_rd  out  5  destination register.
- wb_reg_write  out  1  register write enable.
- addr_err  out  1  misaligned access, qualified by wb_valid.

Behaviour:
- Reset: FSM to IDLE; all outputs 0; takes effect immediately, including mid-access. mem_req drops asynchronously. Any later mem_rvalid for the aborted access is ignored.
- FSM states IDLE, REQ, WAIT.
- stall = ex_valid && state != IDLE, combinational. Non-memory instructions also wait; strictly in-order.
- IDLE, ex_valid=0: wb_valid=0 next cycle.
- IDLE, ex_valid with non-memory op: next cycle wb_valid=1, wb_data=ex_result, wb_rd/wb_reg_write copied. Latency 1; state stays IDLE.
- IDLE, ex_valid with memory op: latch opcode, address, store data, rd. Check alignment: halfword ops need addr[0]=0; word ops need addr[1:0]=0.
  - Misaligned: no memory access. Next cycle wb_valid=1, addr_err=1, wb_reg_write=0, wb_data=address; stay IDLE.
  - Aligned: go to REQ.
- REQ: mem_req=1; mem_addr/mem_we/mem_be/mem_wdata held stable until mem_ready.
  - mem_ready with a store: next cycle wb_valid=1, wb_reg_write=0; go to IDLE.
  - mem_ready with a load: go to WAIT.
- WAIT: mem_req=0; wait any number of cycles. On mem_rvalid: next cycle wb_valid=1, wb_data=extracted value, wb_reg_write=latched value; go to IDLE. mem_rvalid is ignored in IDLE and REQ.
- Store lanes (lane index L=addr[1:0], remapped by BIG_ENDIAN):
  - sb: wdata={4{d[7:0]}}, be=1<<L.
  - sh: wdata={2{d[15:0]}}, be=0011 if addr[1]=0 else 1100.
  - sw: wdata=d, be=1111.
  - Loads: be=1111.
- Load extraction: select the byte or half by lane. lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word.
- Throughput limits:
  - Store with mem_ready held high: accept T, REQ T+1, wb_valid T+2.
  - Load: minimum accept-to-wb_valid latency 3 cycles (rvalid one cycle after ready).
  - Next instruction is accepted in the cycle state returns to IDLE.
- wb_valid is a single-cycle pulse; addr_err=0 whenever not misaligned.

Test Plan:
- Reset then non-memory addu: ex_result=0x0000_1234, rd=5 -> one cycle later wb_valid=1, wb_data=0x1234, wb_rd=5, stall never asserted.
- sb addr=0x1003, data=0xAABBCCDD, BIG_ENDIAN=0, mem_ready high -> mem_addr=0x1000, be=1000, wdata=0xDDDDDDDD. wb_valid two cycles after accept, wb_reg_write=0.
- lb addr=0x2001, mem_rdata=0x1234_80FF, rvalid 4 cycles after ready -> wb_data=0xFFFFFF80. lbu on the same inputs -> 0x00000080. stall high throughout for a following instruction.
- lw addr=0x3002 -> no mem_req. Next cycle wb_valid=1, addr_err=1, wb_data=0x3002, wb_reg_write=0.
- lh addr=0x4002 with mem_ready delayed 3 cycles -> mem_req/addr/be stable all 3 cycles. mem_rdata=0x8001_0000 -> wb_data=0xFFFF8001.
- rst pulsed while in WAIT -> mem_req=0 and outputs 0 immediately. A subsequent mem_rvalid produces no wb_valid. The next ex_valid op is processed normally.
